// File: rtl/prng_range_sampler.sv
// Range sampler: turns 32-bit PRNG words into uniform values in [0, N) by masked
// rejection sampling, with a bounded retry count and a deterministic fallback.
module prng_range_sampler #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      rnd_data,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_limit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_fallback
);

    localparam int unsigned     TriesW   = $clog2(MAX_TRIES + 1);
    localparam logic [TriesW:0] MaxTries = (TriesW + 1)'(MAX_TRIES);

    typedef enum logic [1:0] {StIdle, StSample, StHold} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [TriesW-1:0]   tries_q, tries_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                fallback_q, fallback_d;

    logic [WIDTH:0]      lim_m1;
    logic [WIDTH-1:0]    mask_next;
    logic                trivial;
    logic [WIDTH-1:0]    cand;
    logic [TriesW:0]     tries_inc;
    logic                unused_rnd_hi;

    // Upper PRNG bits beyond WIDTH are deliberately discarded.
    assign unused_rnd_hi = ^rnd_data;

    // limit-1 carries a borrow bit, so limit 0 and 1 both land on the trivial path.
    always_comb begin
        lim_m1    = {1'b0, req_limit} - (WIDTH + 1)'(1);
        trivial   = lim_m1[WIDTH] | (lim_m1[WIDTH-1:0] == '0);
        mask_next = lim_m1[WIDTH-1:0];
        for (int i = 1; i < int'(WIDTH); i = i * 2) begin
            mask_next = mask_next | (mask_next >> i);
        end
    end

    assign cand      = rnd_data[WIDTH-1:0] & mask_q;
    assign tries_inc = {1'b0, tries_q} + (TriesW + 1)'(1);

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        mask_d     = mask_q;
        tries_d    = tries_q;
        data_d     = data_q;
        fallback_d = fallback_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    limit_d = req_limit;
                    mask_d  = mask_next;
                    tries_d = '0;
                    if (trivial) begin
                        data_d     = '0;
                        fallback_d = 1'b0;
                        state_d    = StHold;
                    end else begin
                        state_d = StSample;
                    end
                end
            end
            StSample: begin
                if (rnd_valid) begin
                    tries_d = tries_inc[TriesW-1:0];
                    if (cand < limit_q) begin
                        data_d     = cand;
                        fallback_d = 1'b0;
                        state_d    = StHold;
                    end else if (tries_inc == MaxTries) begin
                        // mask < 2*limit, so a single subtraction lands in range.
                        data_d     = cand - limit_q;
                        fallback_d = 1'b1;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            limit_q    <= '0;
            mask_q     <= '0;
            tries_q    <= '0;
            data_q     <= '0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            mask_q     <= mask_d;
            tries_q    <= tries_d;
            data_q     <= data_d;
            fallback_q <= fallback_d;
        end
    end

    // All outputs forced quiet while reset is asserted.
    assign req_ready    = !reset && (state_q == StIdle);
    assign rnd_ready    = !reset && (state_q == StSample);
    assign out_valid    = !reset && (state_q == StHold);
    assign out_data     = reset ? '0 : data_q;
    assign out_fallback = !reset && fallback_q;

`ifdef FORMAL
    a_in_range: assert property (@(posedge clock) disable iff (reset)
        (out_valid && (limit_q > WIDTH'(1))) |-> (out_data < limit_q));
    a_stable: assert property (@(posedge clock) disable iff (reset)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_fallback)));
    a_tries: assert property (@(posedge clock) disable iff (reset)
        {1'b0, tries_q} <= MaxTries);
    a_rnd_ready: assert property (@(posedge clock)
        rnd_ready |-> (state_q == StSample));
`endif

endmodule

// File: doc/prng_range_sampler.md
Name: prng_range_sampler

Overview:
Downstream consumer of the 32-bit xorshift PRNG stage. Accepts range requests (limit N) over a valid/ready handshake and returns a uniformly distributed value in [0, N). It draws PRNG words through rejection sampling with a bounded retry count and a deterministic fallback. Sits between the PRNG and stimulus/traffic generators that need bounded random values.

Parameters:
WIDTH, 16, width of limit and result; legal range 1..32.
MAX_TRIES, 4, number of PRNG words consumed per request before fallback; legal range ≥1.

Ports:
clock  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rnd_data  input  32  PRNG word from the upstream generator.
rnd_valid  input  1  rnd_data is a fresh word this cycle.
rnd_ready  output  1  sampler consumes rnd_data this cycle.
req_valid  input  1  range request present.
req_ready  output  1  request accepted when req_valid && req_ready.
req_limit  input  WIDTH  exclusive upper bound N.
out_valid  output  1  result present.
out_ready  input  1  result consumed when out_valid && out_ready.
out_data  output  WIDTH  sampled value.
out_fallback  output  1  result came from the fallback path, not clean rejection.

Behaviour:
- Reset (synchronous, reset=1 at a posedge): state IDLE; out_valid=0, out_data=0, out_fallback=0, rnd_ready=0, req_ready=0 during reset cycle; internal limit_q/mask_q/tries cleared. Reset mid-operation aborts the pending request with no output.
- States: IDLE, SAMPLE, HOLD.
- IDLE: req_ready=1, rnd_ready=0, out_valid=0. On accept, latch limit_q=req_limit, mask_q=smallest (2^k−1) ≥ limit_q−1 (limit 2 → 1, 10 → 15, 0x8000 → 0x7FFF), tries=0.
  - limit_q ≤ 1 (including 0): out_data=0, out_fallback=0, go HOLD. No PRNG word consumed.
  - else go SAMPLE.
- SAMPLE: req_ready=0, rnd_ready=1. Cycle with rnd_valid=0: no change, tries not incremented. Cycle with rnd_valid=1: cand = rnd_data[WIDTH-1:0] & mask_q; tries+1.
  - cand < limit_q: out_data=cand, out_fallback=0, go HOLD.
  - else if tries+1 == MAX_TRIES: out_data=cand−limit_q, out_fallback=1, go HOLD. This is always < limit_q because cand ≤ mask_q < 2·limit_q.
  - else stay in SAMPLE.
- HOLD: out_valid=1, rnd_ready=0, req_ready=0. out_data/out_fallback held stable until out_ready=1. On handshake go IDLE. A new request is accepted no earlier than the following cycle.
- Latency: request accepted at edge T → earliest out_valid at T+2 (first word consumed at T+1). For limit ≤ 1 → out_valid at T+1.
- WIDTH=32: mask computation uses WIDTH+1 bits internally. No overflow.
- FORMAL properties (under `ifdef FORMAL`):
  - out_valid && limit_q>1 → out_data < limit_q.
  - out_valid && !out_ready → out_data, out_fallback stable next cycle.
  - tries ≤ MAX_TRIES.
  - rnd_ready → state==SAMPLE.

Test Plan:
- Reject then accept: limit=10, rnd words 0x0000000C, 0x00000007 → out_data=7, out_fallback=0, out_valid 3 cycles after accept, rnd_ready high exactly 2 cycles.
- Fallback: limit=10, MAX_TRIES=4, four words 0xFFFF000E (cand 14) → out_data=4, out_fallback=1 after the 4th word.
- Trivial limits: limit=1 and limit=0 → out_data=0 one cycle after accept, rnd_ready never asserted.
- Stall/backpressure: rnd_valid low 3 cycles in SAMPLE → tries unchanged; out_ready low 5 cycles in HOLD → out_data constant, req_ready=0 throughout.
- Mask edge: limit=0x8000, word 0x1234FFFF (cand 0x7FFF) → out_data=0x7FFF, fallback 0.
- Reset mid-SAMPLE: assert reset for 1 cycle → next cycle state IDLE, out_valid=0, req_ready=1, no stale result emitted.
